posit_decoder_pipe: RTL and testbench



---
 rtl/posit_pkg.sv | 35 +++
 rtl/posit_decoder_pipe_run_count.sv | 26 ++
 rtl/posit_decoder_pipe.sv | 168 ++++++++++++++++
 tb/tb_posit_decoder_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit decoder definitions: derived field widths, special-value flags
// and the N=16/ES=2 reference encodings.
package posit_pkg;

   function automatic int unsigned posit_kw(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

   function automatic int unsigned posit_sw(input int unsigned n, input int unsigned es);
      return posit_kw(n) + es;
   endfunction

   function automatic int unsigned posit_fw(input int unsigned n, input int unsigned es);
      return n - 3 - es;
   endfunction

   // Special-value flags; at most one is ever set.
   typedef struct packed {
      logic nar;
      logic zero;
   } posit_flags_t;

   localparam int unsigned P16_SEL_MAXPOS = 0;
   localparam int unsigned P16_SEL_MINPOS = 1;
   localparam int unsigned P16_SEL_NAR    = 2;

   function automatic logic [15:0] posit16_const(input int unsigned sel);
      case (sel)
         P16_SEL_MAXPOS: return 16'h7FFF;
         P16_SEL_MINPOS: return 16'h0001;
         default:        return 16'h8000;
      endcase
   endfunction

endpackage

// File: rtl/posit_decoder_pipe_run_count.sv
// Combinational leading-run counter: number of MSB-first bits equal to pol_i,
// naturally saturating at W.
module posit_run_count #(
   parameter int unsigned W     = 15,
   parameter int unsigned OUT_W = 5
) (
   input  logic [W-1:0]     vec_i,
   input  logic             pol_i,
   output logic [OUT_W-1:0] run_c_o
);

   logic broken;

   always_comb begin
      run_c_o = '0;
      broken  = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i] != pol_i) begin
            broken = 1'b1;
         end else if (!broken) begin
            run_c_o = run_c_o + OUT_W'(1);
         end
      end
   end

endmodule

// File: rtl/posit_decoder_pipe.sv
// Three-stage posit decoder (capture / regime / extract) with valid-ready
// backpressure, collapsing bubbles and an in-order sideband tag.
module posit_decoder_pipe
   import posit_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned ES    = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic                        clk_i,
   input  logic                        rstn,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N-1:0]                in_posit,
   input  logic [TAG_W-1:0]            in_tag,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_sign,
   output logic [posit_kw(N)-1:0]      out_k,
   output logic [posit_sw(N, ES)-1:0]  out_scale,
   output logic [posit_fw(N, ES):0]    out_frac,
   output logic                        out_zero,
   output logic                        out_nar,
   output logic [TAG_W-1:0]            out_tag
);

   localparam int unsigned KW  = posit_kw(N);
   localparam int unsigned SW  = posit_sw(N, ES);
   localparam int unsigned FW  = posit_fw(N, ES);
   localparam int unsigned FRW = FW + 1;
   localparam int unsigned MW  = N - 1;

   logic s1_ld, s2_ld, s3_ld;

   logic               s1_valid_q, s1_sign_q, s1_sign_d;
   logic [MW-1:0]      s1_mag_q, s1_mag_d;
   posit_flags_t       s1_flags_q, s1_flags_d;
   logic [TAG_W-1:0]   s1_tag_q;

   logic               s2_valid_q, s2_sign_q;
   logic [MW-1:0]      s2_mag_q;
   logic [KW-1:0]      s2_run_q, s2_run_d;
   logic signed [KW-1:0] s2_k_q, s2_k_d;
   posit_flags_t       s2_flags_q;
   logic [TAG_W-1:0]   s2_tag_q;

   logic               s3_valid_q, s3_sign_q;
   logic [KW-1:0]      s3_k_q;
   logic [SW-1:0]      s3_scale_q, s3_scale_d, s3_e;
   logic [FRW-1:0]     s3_frac_q, s3_frac_d;
   posit_flags_t       s3_flags_q;
   logic [TAG_W-1:0]   s3_tag_q;
   logic [MW-1:0]      s3_sh, s3_fb;

   // A stage loads when it is empty or its content moves on this cycle.
   assign s3_ld    = !s3_valid_q || out_ready;
   assign s2_ld    = !s2_valid_q || s3_ld;
   assign s1_ld    = !s1_valid_q || s2_ld;
   assign in_ready = s1_ld;

   always_comb begin
      s1_flags_d.zero = (in_posit == '0);
      s1_flags_d.nar  = (in_posit == {1'b1, {MW{1'b0}}});
      s1_sign_d       = in_posit[N-1] & ~s1_flags_d.nar;
      s1_mag_d        = in_posit[N-1] ? MW'(~in_posit + N'(1)) : in_posit[MW-1:0];
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_mag_q   <= '0;
         s1_flags_q <= '0;
         s1_tag_q   <= '0;
      end else if (s1_ld) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_flags_q <= s1_flags_d;
            s1_tag_q   <= in_tag;
         end
      end
   end

   posit_run_count #(
      .W     (MW),
      .OUT_W (KW)
   ) u_run_count (
      .vec_i   (s1_mag_q),
      .pol_i   (s1_mag_q[MW-1]),
      .run_c_o (s2_run_d)
   );

   always_comb begin
      s2_k_d = '0;
      if (!(s1_flags_q.zero || s1_flags_q.nar)) begin
         s2_k_d = s1_mag_q[MW-1] ? s2_run_d - KW'(1) : KW'(0) - s2_run_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s2_valid_q <= 1'b0;
         s2_sign_q  <= 1'b0;
         s2_mag_q   <= '0;
         s2_run_q   <= '0;
         s2_k_q     <= '0;
         s2_flags_q <= '0;
         s2_tag_q   <= '0;
      end else if (s2_ld) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sign_q  <= s1_sign_q;
            s2_mag_q   <= s1_mag_q;
            s2_run_q   <= s2_run_d;
            s2_k_q     <= s2_k_d;
            s2_flags_q <= s1_flags_q;
            s2_tag_q   <= s1_tag_q;
         end
      end
   end

   // Shifting out regime+terminator leaves e then fraction MSB-aligned, zero-filled.
   always_comb begin
      s3_sh      = s2_mag_q << (s2_run_q + KW'(1));
      s3_e       = SW'(s3_sh >> (MW - ES));
      s3_fb      = s3_sh << ES;
      s3_frac_d  = FRW'({1'b1, s3_fb} >> (ES + 2));
      s3_scale_d = (SW'(s2_k_q) << ES) | s3_e;
      if (s2_flags_q.zero || s2_flags_q.nar) begin
         s3_frac_d  = '0;
         s3_scale_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
         s3_valid_q <= 1'b0;
         s3_sign_q  <= 1'b0;
         s3_k_q     <= '0;
         s3_scale_q <= '0;
         s3_frac_q  <= '0;
         s3_flags_q <= '0;
         s3_tag_q   <= '0;
      end else if (s3_ld) begin
         s3_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            s3_sign_q  <= s2_sign_q;
            s3_k_q     <= s2_k_q;
            s3_scale_q <= s3_scale_d;
            s3_frac_q  <= s3_frac_d;
            s3_flags_q <= s2_flags_q;
            s3_tag_q   <= s2_tag_q;
         end
      end
   end

   assign out_valid = s3_valid_q;
   assign out_sign  = s3_sign_q;
   assign out_k     = s3_k_q;
   assign out_scale = s3_scale_q;
   assign out_frac  = s3_frac_q;
   assign out_zero  = s3_flags_q.zero;
   assign out_nar   = s3_flags_q.nar;
   assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Bench for posit_decoder_pipe (N=16, ES=2): directed values, backpressure,
// bubbles, random traffic and mid-stream reset against a bit-queue decode model.
module tb_posit_decoder_pipe;
   import posit_pkg::*;

   localparam int unsigned N     = 16;
   localparam int unsigned ES    = 2;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned KW    = posit_kw(N);
   localparam int unsigned SW    = posit_sw(N, ES);
   localparam int unsigned FW    = posit_fw(N, ES);
   localparam int unsigned FRW   = FW + 1;

   typedef struct packed {
      logic             sign;
      logic [KW-1:0]    k;
      logic [SW-1:0]    scale;
      logic [FRW-1:0]   frac;
      logic             zero;
      logic             nar;
      logic [TAG_W-1:0] tag;
   } res_t;

   typedef struct {
      res_t r;
      int   cyc;
   } exp_t;

   logic clk_i = 1'b0;
   logic rstn  = 1'b0;
   logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [N-1:0]     in_posit = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_sign, out_zero, out_nar;
   logic [KW-1:0]    out_k;
   logic [SW-1:0]    out_scale;
   logic [FRW-1:0]   out_frac;
   logic [TAG_W-1:0] out_tag;
   res_t             dut_r;

   int   n_chk = 0, n_err = 0, n_cyc = 0, n_in = 0, n_out = 0, n_block = 0;
   int   base_in, base_out, base_block;
   exp_t exp_q[$];
   bit   dir_on = 0, chk_lat = 0, inflight_chk = 0, stall_prev = 0;
   res_t dir_exp, held;
   logic [N-1:0] d_in [8];
   res_t         d_exp [8];

   always #5 clk_i = ~clk_i;

   posit_decoder_pipe #(.N(N), .ES(ES), .TAG_W(TAG_W)) dut (
      .clk_i     (clk_i),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_posit  (in_posit),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_k     (out_k),
      .out_scale (out_scale),
      .out_frac  (out_frac),
      .out_zero  (out_zero),
      .out_nar   (out_nar),
      .out_tag   (out_tag)
   );

   assign dut_r = {out_sign, out_k, out_scale, out_frac, out_zero, out_nar, out_tag};

   // Reads the posit as a bit string: regime run, terminator, ES exponent bits, fraction.
   function automatic res_t model(input logic [N-1:0] x, input logic [TAG_W-1:0] t);
      res_t r;
      bit q[$];
      bit rb;
      logic [N-2:0] m;
      int run, k, e, fr;
      r = '0;
      r.tag = t;
      if (x == '0) begin
         r.zero = 1'b1;
         return r;
      end
      if (x == {1'b1, {(N-1){1'b0}}}) begin
         r.nar = 1'b1;
         return r;
      end
      r.sign = x[N-1];
      m = x[N-1] ? (N-1)'(-x) : x[N-2:0];
      for (int i = N - 2; i >= 0; i--) q.push_back(m[i]);
      rb = q[0];
      run = 0;
      while (q.size() > 0 && q[0] == rb) begin
         void'(q.pop_front());
         run++;
      end
      if (q.size() > 0) void'(q.pop_front());
      k = rb ? run - 1 : -run;
      e = 0;
      for (int i = 0; i < int'(ES); i++) e = e * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
      fr = 1;
      for (int i = 0; i < int'(FW); i++) fr = fr * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
      r.k     = KW'(k);
      r.scale = SW'(k * (2 ** ES) + e);
      r.frac  = FRW'(fr);
      return r;
   endfunction

   function automatic res_t mk(input logic s, input int k, input int sc, input int fr,
                               input logic z, input logic n, input int t);
      res_t r;
      r.sign = s; r.k = KW'(k); r.scale = SW'(sc); r.frac = FRW'(fr);
      r.zero = z; r.nar = n; r.tag = TAG_W'(t);
      return r;
   endfunction

   function automatic logic [N-1:0] rand_posit();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return posit16_const(P16_SEL_NAR);
         2:       return posit16_const(P16_SEL_MAXPOS) ^ N'($urandom_range(0, 3));
         3:       return posit16_const(P16_SEL_MINPOS) << $urandom_range(0, 3);
         default: return N'($urandom);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: sample at negedge, score handshakes, return 1 time unit past posedge.
   task automatic step();
      exp_t e;
      int   inflight;
      @(negedge clk_i);
      n_cyc++;
      inflight = n_in - n_out;
      if (inflight_chk) chk("in_ready", 32'(in_ready), 32'(inflight < 3 || out_ready));
      if (stall_prev) chk("stall_hold", {out_valid, dut_r}, {1'b1, held});
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("result", 32'(dut_r), 32'(e.r));
            if (chk_lat) chk("latency", 32'(n_cyc - e.cyc), 32'd3);
         end
         n_out++;
      end
      if (in_valid && !in_ready) n_block++;
      if (in_valid && in_ready) begin
         e.r   = dir_on ? dir_exp : model(in_posit, in_tag);
         e.cyc = n_cyc;
         exp_q.push_back(e);
         n_in++;
      end
      stall_prev = out_valid && !out_ready;
      held = dut_r;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain(input int max_cyc);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < max_cyc && exp_q.size() > 0; j++) step();
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      d_in  = '{16'h4000, 16'h5A00, 16'hC000, 16'h7FFF, 16'h0001, 16'h7FFE, 16'h0000, 16'h8000};
      d_exp[0] = mk(0,   0,   0, 'h800, 0, 0, 0);
      d_exp[1] = mk(0,   0,   3, 'hA00, 0, 0, 1);
      d_exp[2] = mk(1,   0,   0, 'h800, 0, 0, 2);
      d_exp[3] = mk(0,  14,  56, 'h800, 0, 0, 3);
      d_exp[4] = mk(0, -14, -56, 'h800, 0, 0, 4);
      d_exp[5] = mk(0,  13,  52, 'h800, 0, 0, 5);
      d_exp[6] = mk(0,   0,   0, 'h000, 1, 0, 6);
      d_exp[7] = mk(0,   0,   0, 'h000, 0, 1, 7);

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_outputs", 32'(dut_r), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk_i);
      rstn = 1'b1;
      @(posedge clk_i);
      #1;
      inflight_chk = 1;

      // Directed values, one at a time, with latency
      out_ready = 1'b1;
      chk_lat   = 1;
      dir_on    = 1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_posit = d_in[i];
         in_tag   = TAG_W'(i);
         dir_exp  = d_exp[i];
         step();
         in_valid = 1'b0;
         in_posit = N'($urandom);
         in_tag   = TAG_W'($urandom);
         drain(10);
      end
      dir_on  = 0;
      chk_lat = 0;

      // Backpressure: 8 tagged operands, out_ready low for cycles 4..9
      base_in = n_in; base_out = n_out; base_block = n_block;
      for (int c = 0; c < 40; c++) begin
         out_ready = !(c >= 4 && c <= 9);
         in_valid  = (n_in - base_in) < 8;
         in_posit  = rand_posit();
         in_tag    = TAG_W'(n_in - base_in);
         step();
      end
      drain(10);
      chk("bp_count", 32'(n_out - base_out), 32'd8);
      chk("bp_in_ready_dropped", 32'(n_block > base_block), 32'd1);

      // Bubbles: in_valid every third cycle, out_ready toggling
      base_in = n_in; base_out = n_out;
      for (int c = 0; c < 60; c++) begin
         in_valid  = (c % 3) == 0;
         in_posit  = rand_posit();
         in_tag    = TAG_W'($urandom);
         out_ready = (c % 2) == 1;
         step();
      end
      drain(12);
      chk("bubble_count", 32'(n_out - base_out), 32'(n_in - base_in));

      // Random traffic
      base_in = n_in; base_out = n_out;
      for (int c = 0; c < 300; c++) begin
         in_valid  = $urandom_range(0, 9) < 7;
         in_posit  = rand_posit();
         in_tag    = TAG_W'($urandom);
         out_ready = $urandom_range(0, 9) < 6;
         step();
      end
      drain(12);
      chk("random_count", 32'(n_out - base_out), 32'(n_in - base_in));

      // Reset with three operands in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_posit = rand_posit();
         in_tag   = TAG_W'(i);
         step();
      end
      in_valid = 1'b0;
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      rstn = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_outputs", 32'(dut_r), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      n_in = 0; n_out = 0; stall_prev = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rstn = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready = 1'b1;
      chk_lat   = 1;
      in_valid  = 1'b1;
      in_posit  = 16'h5A00;
      in_tag    = TAG_W'(9);
      step();
      in_valid = 1'b0;
      for (int j = 0; j < 6; j++) step();
      chk("post_reset_count", 32'(n_out), 32'd1);
      chk("post_reset_left", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
